// File: rtl/spi_cmd_pkg.sv
// Shared opcodes, header field positions and parser state encoding for the SPI command controller.
package spi_cmd_pkg;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_BURST = 2'b11;

  localparam int HDR_OP_HI   = 7;
  localparam int HDR_OP_LO   = 6;
  localparam int HDR_RSV_HI  = 5;
  localparam int HDR_RSV_LO  = 4;
  localparam int HDR_ADDR_LO = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_WAIT_DATA,
    S_DATA,
    S_WAIT_LEN,
    S_LEN,
    S_WAIT_BURST,
    S_BURST
  } state_t;

endpackage

// File: rtl/spi_cmd_regfile.sv
// Control register file: one write port, one combinational read port, flattened output bus.
module spi_cmd_regfile #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [7:0]            wr_data,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [7:0]            rd_data,
  output logic [NUM_REGS*8-1:0] regs_flat
);

  logic [NUM_REGS-1:0][7:0] mem;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)   mem <= '0;
    else if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data   = mem[rd_addr];
  assign regs_flat = mem;

endmodule

// File: rtl/spi_cmd_controller.sv
// Pops the SPI RX FIFO, parses NOP/WRITE/READ/BURST packets and executes them on the register file.
// Optional inter-byte timeout: define SPI_CMD_TIMEOUT_EN.
module spi_cmd_controller
  import spi_cmd_pkg::*;
#(
  parameter int NUM_REGS       = 16,
  parameter int ADDR_W         = 4,
  parameter int TIMEOUT_CYCLES = 270000,
  parameter int TO_W           = 20
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [7:0]            fifo_data,
  input  logic                  fifo_empty,
  output logic                  fifo_read_en,
  output logic [7:0]            tx_byte,
  output logic [NUM_REGS*8-1:0] ctrl_regs,
  output logic                  reg_wr_strobe,
  output logic [ADDR_W-1:0]     reg_wr_addr,
  output logic                  cmd_error,
  output logic                  busy,
  output logic [7:0]            pkt_count
);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr_q, addr_nx;
  logic [7:0]        remain_q, remain_nx;
  logic              pop, wr_en, err, pkt_inc, tx_load, timeout;
  logic [7:0]        rd_data;
  logic [1:0]        hdr_op;
  logic              hdr_bad;
  logic [ADDR_W-1:0] hdr_addr;

  assign hdr_op   = fifo_data[HDR_OP_HI:HDR_OP_LO];
  assign hdr_bad  = |fifo_data[HDR_RSV_HI:HDR_RSV_LO];
  assign hdr_addr = fifo_data[HDR_ADDR_LO +: ADDR_W];

  spi_cmd_regfile #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) u_regfile (
    .clock     (clock),
    .reset_n   (reset_n),
    .wr_en     (wr_en),
    .wr_addr   (addr_q),
    .wr_data   (fifo_data),
    .rd_addr   (hdr_addr),
    .rd_data   (rd_data),
    .regs_flat (ctrl_regs)
  );

  always_comb begin
    state_nx  = state;
    addr_nx   = addr_q;
    remain_nx = remain_q;
    pop       = 1'b0;
    wr_en     = 1'b0;
    err       = 1'b0;
    pkt_inc   = 1'b0;
    tx_load   = 1'b0;
    case (state)
      S_IDLE: if (!fifo_empty) begin pop = 1'b1; state_nx = S_HDR; end
      S_HDR: begin
        addr_nx = hdr_addr;
        if (hdr_bad) begin
          err      = 1'b1;
          state_nx = S_IDLE;
        end else begin
          case (hdr_op)
            OP_WRITE: state_nx = S_WAIT_DATA;
            OP_BURST: state_nx = S_WAIT_LEN;
            OP_READ:  begin tx_load = 1'b1; pkt_inc = 1'b1; state_nx = S_IDLE; end
            default:  begin pkt_inc = 1'b1; state_nx = S_IDLE; end
          endcase
        end
      end
      S_WAIT_DATA: begin
        if (!fifo_empty)  begin pop = 1'b1; state_nx = S_DATA; end
        else if (timeout) begin err = 1'b1; state_nx = S_IDLE; end
      end
      S_DATA: begin wr_en = 1'b1; pkt_inc = 1'b1; state_nx = S_IDLE; end
      S_WAIT_LEN: begin
        if (!fifo_empty)  begin pop = 1'b1; state_nx = S_LEN; end
        else if (timeout) begin err = 1'b1; state_nx = S_IDLE; end
      end
      S_LEN: begin
        if (fifo_data == 8'd0) begin
          err      = 1'b1;
          state_nx = S_IDLE;
        end else begin
          remain_nx = fifo_data;
          state_nx  = S_WAIT_BURST;
        end
      end
      S_WAIT_BURST: begin
        if (!fifo_empty)  begin pop = 1'b1; state_nx = S_BURST; end
        else if (timeout) begin err = 1'b1; state_nx = S_IDLE; end
      end
      S_BURST: begin
        // address width equals log2(NUM_REGS), so the increment wraps naturally
        wr_en     = 1'b1;
        addr_nx   = addr_q + 1'b1;
        remain_nx = remain_q - 8'd1;
        if (remain_q == 8'd1) begin
          pkt_inc  = 1'b1;
          state_nx = S_IDLE;
        end else begin
          state_nx = S_WAIT_BURST;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

`ifdef SPI_CMD_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      to_cnt <= '0;
    else if (pop || state == S_IDLE)
      to_cnt <= '0;
    else if (state == S_WAIT_DATA || state == S_WAIT_LEN || state == S_WAIT_BURST)
      to_cnt <= to_cnt + 1'b1;
  end

  assign timeout = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      addr_q        <= '0;
      remain_q      <= '0;
      tx_byte       <= '0;
      pkt_count     <= '0;
      reg_wr_strobe <= 1'b0;
      reg_wr_addr   <= '0;
      cmd_error     <= 1'b0;
    end else begin
      state         <= state_nx;
      addr_q        <= addr_nx;
      remain_q      <= remain_nx;
      reg_wr_strobe <= wr_en;
      cmd_error     <= err;
      if (tx_load) tx_byte     <= rd_data;
      if (pkt_inc) pkt_count   <= pkt_count + 8'd1;
      if (wr_en)   reg_wr_addr <= addr_q;
    end
  end

  // gated so a non-empty FIFO cannot see a pop while reset is held
  assign fifo_read_en = pop & reset_n;
  assign busy         = (state != S_IDLE);

endmodule

// File: tb/tb_spi_cmd_controller.sv
// Directed and randomized checks of spi_cmd_controller against a packet-level reference model.
module tb_spi_cmd_controller;

  localparam int NR = 16;
  localparam int AW = 4;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic [7:0]        fifo_data = 8'h00;
  logic              fifo_empty = 1'b1;
  logic              fifo_read_en;
  logic [7:0]        tx_byte;
  logic [NR*8-1:0]   ctrl_regs;
  logic              reg_wr_strobe;
  logic [AW-1:0]     reg_wr_addr;
  logic              cmd_error;
  logic              busy;
  logic [7:0]        pkt_count;

  spi_cmd_controller #(.NUM_REGS(NR), .ADDR_W(AW), .TIMEOUT_CYCLES(100), .TO_W(20)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .fifo_data     (fifo_data),
    .fifo_empty    (fifo_empty),
    .fifo_read_en  (fifo_read_en),
    .tx_byte       (tx_byte),
    .ctrl_regs     (ctrl_regs),
    .reg_wr_strobe (reg_wr_strobe),
    .reg_wr_addr   (reg_wr_addr),
    .cmd_error     (cmd_error),
    .busy          (busy),
    .pkt_count     (pkt_count)
  );

  always #5 clock = ~clock;

  logic [7:0] q[$];
  logic [7:0] stim[$];
  int checks = 0, errors = 0, cyc = 0;
  int pops = 0, pushed = 0, bad_pops = 0, strobes = 0, errs = 0;
  int first_pop = -1, last_pop = -1, tx_cyc = -1;
  logic [AW-1:0] last_wr_addr = '0;
  logic [7:0] prev_tx = 8'h00;

  logic [7:0] m_regs [NR];
  logic [7:0] m_tx = 8'h00, m_pkt = 8'h00;
  int m_strobes = 0, m_errs = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] reg_of(input int i);
    return ctrl_regs[8*i +: 8];
  endfunction

  // one clock: sample pop mid-cycle, serve the FIFO after the edge, monitor pulses
  task automatic tick();
    logic p;
    #4;
    p = fifo_read_en;
    if (p && q.size() == 0) bad_pops++;
    @(posedge clock);
    #1;
    cyc++;
    if (p && q.size() != 0) begin
      fifo_data = q.pop_front();
      pops++;
      if (first_pop < 0) first_pop = cyc - 1;
      last_pop = cyc - 1;
    end
    fifo_empty = (q.size() == 0);
    if (reg_wr_strobe) begin strobes++; last_wr_addr = reg_wr_addr; end
    if (cmd_error) errs++;
    if (tx_byte !== prev_tx) begin tx_cyc = cyc; prev_tx = tx_byte; end
  endtask

  task automatic push_all();
    foreach (stim[i]) q.push_back(stim[i]);
    pushed += stim.size();
    fifo_empty = (q.size() == 0);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((q.size() != 0 || busy) && n < 3000) begin tick(); n++; end
    tick();
    chk(tag, 32'(n < 3000), 32'd1);
  endtask

  // packet-level reference: walks the byte stream by the command rules
  task automatic model();
    int i, n;
    logic [7:0] h;
    logic [AW-1:0] a;
    i = 0;
    while (i < stim.size()) begin
      h = stim[i]; i++;
      a = h[AW-1:0];
      if (h[5:4] != 2'b00) m_errs++;
      else if (h[7:6] == 2'b00) m_pkt++;
      else if (h[7:6] == 2'b10) begin m_tx = m_regs[a]; m_pkt++; end
      else if (h[7:6] == 2'b01) begin m_regs[a] = stim[i]; i++; m_strobes++; m_pkt++; end
      else begin
        n = int'(stim[i]); i++;
        if (n == 0) m_errs++;
        else begin
          for (int k = 0; k < n; k++) begin
            m_regs[(int'(a) + k) % NR] = stim[i]; i++; m_strobes++;
          end
          m_pkt++;
        end
      end
    end
  endtask

  task automatic gen_pkt();
    int kind, n;
    logic [7:0] h;
    kind = $urandom_range(0, 9);
    h = 8'($urandom) & 8'hCF;
    if (kind == 0) begin
      h[5:4] = 2'($urandom_range(1, 3));
      stim.push_back(h);
      return;
    end
    stim.push_back(h);
    case (h[7:6])
      2'b01: stim.push_back(8'($urandom));
      2'b11: begin
        n = (kind == 1) ? 0 : $urandom_range(1, 20);
        stim.push_back(8'(n));
        for (int k = 0; k < n; k++) stim.push_back(8'($urandom));
      end
      default: ;
    endcase
  endtask

  task automatic compare_all(input string tag);
    for (int i = 0; i < NR; i++) chk($sformatf("%s_reg%0d", tag, i), 32'(reg_of(i)), 32'(m_regs[i]));
    chk({tag, "_tx"}, 32'(tx_byte), 32'(m_tx));
    chk({tag, "_pkt"}, 32'(pkt_count), 32'(m_pkt));
    chk({tag, "_strobes"}, strobes, m_strobes);
    chk({tag, "_errs"}, errs, m_errs);
    chk({tag, "_pops"}, pops, pushed);
    chk({tag, "_bad_pops"}, bad_pops, 0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic random_round(input string tag);
    stim.delete();
    repeat ($urandom_range(1, 4)) gen_pkt();
    model();
    if ($urandom_range(0, 1) == 1) push_all();
    else begin
      foreach (stim[i]) begin
        q.push_back(stim[i]); pushed++; fifo_empty = 1'b0;
        repeat ($urandom_range(0, 5)) tick();
      end
    end
    drain({tag, "_drain"});
    compare_all(tag);
  endtask

  initial begin
    int s0, e0, p0, n;
    for (int i = 0; i < NR; i++) m_regs[i] = 8'h00;

    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_regs", 32'(ctrl_regs == '0), 32'd1);
    chk("rst_pkt", 32'(pkt_count), 32'd0);
    chk("rst_tx", 32'(tx_byte), 32'd0);
    chk("rst_strobe", 32'(reg_wr_strobe), 32'd0);
    chk("rst_err", 32'(cmd_error), 32'd0);
    chk("rst_rden", 32'(fifo_read_en), 32'd0);
    reset_n = 1'b1;
    repeat (2) tick();

    // WRITE
    stim = '{8'h43, 8'h5A}; model();
    s0 = strobes; p0 = pops;
    push_all(); drain("wr_drain");
    chk("wr_reg3", 32'(reg_of(3)), 32'h5A);
    chk("wr_strobes", strobes - s0, 1);
    chk("wr_addr", 32'(last_wr_addr), 32'd3);
    chk("wr_pkt", 32'(pkt_count), 32'd1);
    chk("wr_pops", pops - p0, 2);

    // READ
    stim = '{8'h83}; model();
    push_all(); drain("rd_drain");
    chk("rd_tx", 32'(tx_byte), 32'h5A);
    chk("rd_latency", 32'((tx_cyc - last_pop) <= 2), 32'd1);
    chk("rd_pkt", 32'(pkt_count), 32'd2);
    compare_all("rd");

    // BURST wrapping past the top register, back-to-back bytes
    stim = '{8'hCE, 8'h03, 8'h11, 8'h22, 8'h33}; model();
    s0 = strobes; first_pop = -1;
    push_all(); drain("bu_drain");
    chk("bu_reg14", 32'(reg_of(14)), 32'h11);
    chk("bu_reg15", 32'(reg_of(15)), 32'h22);
    chk("bu_reg0", 32'(reg_of(0)), 32'h33);
    chk("bu_strobes", strobes - s0, 3);
    chk("bu_rate", last_pop - first_pop, 8);
    chk("bu_tx_hold", 32'(tx_byte), 32'h5A);

    // bad reserved bits, then a good write
    stim = '{8'h20, 8'h41, 8'h77}; model();
    e0 = errs;
    push_all(); drain("rsv_drain");
    chk("rsv_err", errs - e0, 1);
    chk("rsv_reg1", 32'(reg_of(1)), 32'h77);
    chk("rsv_pkt", 32'(pkt_count), 32'd4);

    // zero-length burst
    stim = '{8'hC0, 8'h00}; model();
    e0 = errs; s0 = strobes;
    push_all(); drain("len0_drain");
    chk("len0_err", errs - e0, 1);
    chk("len0_nowr", strobes - s0, 0);
    chk("len0_pkt", 32'(pkt_count), 32'd4);
    compare_all("len0");

    // starved WRITE waits forever without the timeout feature
    stim = '{8'h45}; push_all();
    e0 = errs;
    repeat (150) tick();
    chk("starve_busy", 32'(busy), 32'd1);
    chk("starve_noerr", errs - e0, 0);
    stim = '{8'h45, 8'h99}; model();
    q.push_back(8'h99); pushed++; fifo_empty = 1'b0;
    drain("starve_drain");
    compare_all("starve");

    for (int r = 0; r < 20; r++) random_round($sformatf("rnd%0d", r));

    // reset in the middle of a burst
    stim = '{8'hC2, 8'h06, 8'h01, 8'h02, 8'h03};
    s0 = strobes;
    push_all();
    n = 0;
    while (strobes < s0 + 2 && n < 100) begin tick(); n++; end
    chk("mid_reach", 32'(n < 100), 32'd1);
    m_strobes += strobes - s0;
    reset_n = 1'b0;
    #1;
    chk("mid_regs", 32'(ctrl_regs == '0), 32'd1);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_pkt", 32'(pkt_count), 32'd0);
    chk("mid_tx", 32'(tx_byte), 32'd0);
    chk("mid_strobe", 32'(reg_wr_strobe), 32'd0);
    chk("mid_wraddr", 32'(reg_wr_addr), 32'd0);
    chk("mid_err", 32'(cmd_error), 32'd0);
    pushed -= q.size();
    q.delete();
    fifo_empty = 1'b1;
    for (int i = 0; i < NR; i++) m_regs[i] = 8'h00;
    m_tx = 8'h00; m_pkt = 8'h00;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    for (int r = 0; r < 3; r++) random_round($sformatf("post%0d", r));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_cmd_controller.md
Name: spi_cmd_controller

Overview:
Sequences the SPI slave's RX FIFO: pops received bytes, parses them into command packets, and executes them against an internal control register file. Sits between the SPI slave's FIFO pop interface and the top-level logic. Drives the slave's transmit byte so a READ result is shifted out on the next CS-low transfer. Exports all control registers flat to top level.

Parameters:
NUM_REGS, 16, number of 8-bit control registers (power of 2, max 16).
ADDR_W, 4, register address width (log2 NUM_REGS).
TIMEOUT_CYCLES, 270000, inter-byte timeout in clock cycles (10 ms at 27 MHz); used only with the optional feature.
TO_W, 20, timeout counter width.

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
fifo_data  in  8  RX FIFO data_out; valid the cycle after fifo_read_en
fifo_empty  in  1  RX FIFO empty flag
fifo_read_en  out  1  single-cycle RX FIFO pop
tx_byte  out  8  to SPI slave data_to_send
ctrl_regs  out  NUM_REGS*8  flattened register file; reg i at [8i+7:8i]
reg_wr_strobe  out  1  one-cycle pulse per register write
reg_wr_addr  out  ADDR_W  address of the last write
cmd_error  out  1  one-cycle pulse on a malformed or aborted packet
busy  out  1  high while a packet is in progress (state != IDLE)
pkt_count  out  8  completed good packets, wraps 255->0

Behaviour:
- Reset (async assert, sync deassert): state IDLE; all ctrl_regs, tx_byte, pkt_count, reg_wr_addr = 0; fifo_read_en, reg_wr_strobe, cmd_error, busy = 0.
- Header byte: [7:6] opcode, [5:4] must be 00, [3:0] addr.
- Opcode 00 NOP: no action; pkt_count+1.
- Opcode 01 WRITE: header, then 1 data byte; regs[addr] <= data.
- Opcode 10 READ: tx_byte <= regs[addr] one cycle after the header is sampled; pkt_count+1.
- Opcode 11 BURST: header, length N (1..255), then N data bytes to addr, addr+1, ...
- Burst addressing: address wraps mod NUM_REGS.
- Byte fetch:
  - A WAIT_* state with fifo_empty=0 asserts fifo_read_en for exactly one cycle, then moves to the matching sample state.
  - The sample state latches fifo_data.
  - There is never more than one pop per byte, and never a pop while fifo_empty=1.
- States:
  - IDLE -> HDR (pop issued) -> decode.
  - WRITE path: WAIT_DATA -> DATA -> IDLE.
  - BURST path: WAIT_LEN -> LEN -> WAIT_BURST -> BURST, looping until the remaining count = 0, then IDLE.
  - NOP and READ: HDR -> IDLE.
- Fastest throughput: 2 cycles per byte when the FIFO stays non-empty.
- Register write timing: lands in the DATA/BURST cycle. reg_wr_strobe and reg_wr_addr are registered together with it and are visible the next cycle.
- pkt_count increments in the cycle the packet's last byte is consumed.
- Errors: cmd_error pulses and the state returns to IDLE, dropping only bytes already consumed; no registers change for the offending byte. Error cases:
  - header[5:4] != 00
  - length byte = 0
- READ of a register written earlier in the same cycle: not possible, because packets are serial.
- Burst semantics: N > NUM_REGS overwrites wrapped registers in order, and the last write wins.
- tx_byte holds its value until the next READ; WRITE and BURST do not alter it.
- reset_n asserted mid-packet: the partial packet is discarded. Bytes still in the FIFO are parsed as a fresh header after release; the FIFO has its own reset.

Optional Feature:
- Macro: SPI_CMD_TIMEOUT_EN.
- Defined:
  - A TO_W counter clears on every pop and counts in WAIT_DATA, WAIT_LEN and WAIT_BURST.
  - On reaching TIMEOUT_CYCLES-1: cmd_error pulses, state -> IDLE, and the partial burst keeps any registers already written.
  - The counter is idle in IDLE.
- Undefined: no counter; WAIT states wait indefinitely.

Decomposition:
- Package spi_cmd_pkg:
  - opcode localparams OP_NOP / OP_WRITE / OP_READ / OP_BURST
  - state encodings
  - header field bit positions
- Sub-module spi_cmd_regfile: NUM_REGS x 8 registers, async reset, one write port (en, addr, data), one combinational read port, flattened output bus.
- Parser FSM stays in spi_cmd_controller.

Test Plan:
- Push 0x43,0x5A -> regs[3]=0x5A; one reg_wr_strobe with addr 3; pkt_count=1; exactly 2 pops.
- After that write, push 0x83 -> tx_byte=0x5A within 2 cycles of the pop; regs unchanged; pkt_count=2.
- Push 0xCE,0x03,0x11,0x22,0x33 -> regs[14]=0x11, regs[15]=0x22, regs[0]=0x33 (wrap); 3 strobes.
- Push 0x20 then 0x41,0x77 -> cmd_error pulse on 0x20; then regs[1]=0x77; pkt_count counts only the second packet.
- Push 0xC0,0x00 -> cmd_error; no register write. Assert reset_n low mid-burst -> all outputs return to reset values immediately.
- With SPI_CMD_TIMEOUT_EN, TIMEOUT_CYCLES=100: push 0x45 only, hold the FIFO empty -> cmd_error at cycle 100 after the pop; busy=0. Without the macro, busy stays 1.
